// File: rtl/udp_tx_packetizer.sv
// Buffers radar sample words in a FIFO and hands them to a UDP sender one packet at a time.
// Optional macro UDP_TX_SEQ_EN prefixes each packet with a 32-bit packet sequence number.
module udp_tx_packetizer #(
   parameter int unsigned WORDS_PER_PKT = 256,
   parameter int unsigned FIFO_AW       = 9,
   parameter int unsigned IFG_CYCLES    = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        tx_start,
   output logic [15:0] tx_data_length,
   output logic [15:0] tx_total_length,
   input  logic        data_req,
   output logic [31:0] datain,
   input  logic        txen,
   output logic        busy,
   output logic        underrun
);

   localparam int unsigned FIFO_DEPTH = 2 ** FIFO_AW;
   localparam int unsigned CW         = FIFO_AW + 1;
   localparam int unsigned OW         = $clog2(WORDS_PER_PKT + 1);
   localparam int unsigned GW         = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   localparam int unsigned GAP_LAST   = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;
`ifdef UDP_TX_SEQ_EN
   localparam int unsigned THRESH     = WORDS_PER_PKT - 1;
`else
   localparam int unsigned THRESH     = WORDS_PER_PKT;
`endif

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      WAIT_TX = 3'd2,
      SENDING = 3'd3,
      GAP     = 3'd4
   } state_t;

   state_t            state;
   logic [31:0]       mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [CW-1:0]     count;
   logic [OW-1:0]     owed;
   logic [GW-1:0]     gap_cnt;
   logic              wr_en;
   logic              serve;
   logic              rd_en;
`ifdef UDP_TX_SEQ_EN
   logic [31:0]       seq_num;
   logic              seq_word;
`endif

   assign tx_data_length  = 16'(8 + 4 * WORDS_PER_PKT);
   assign tx_total_length = 16'(28 + 4 * WORDS_PER_PKT);

   assign s_ready = (count != CW'(FIFO_DEPTH));
   assign wr_en   = s_valid && s_ready;
   // A request is only honoured while a packet is open and words are still owed.
   assign serve   = data_req && (owed != '0) && ((state == WAIT_TX) || (state == SENDING));
`ifdef UDP_TX_SEQ_EN
   assign seq_word = (owed == OW'(WORDS_PER_PKT));
   assign rd_en    = serve && !seq_word;
`else
   assign rd_en    = serve;
`endif

   // FIFO storage; contents need no reset since the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem[wr_ptr] <= s_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         owed     <= '0;
         gap_cnt  <= '0;
         tx_start <= 1'b0;
         busy     <= 1'b0;
         datain   <= '0;
         underrun <= 1'b0;
`ifdef UDP_TX_SEQ_EN
         seq_num  <= '0;
`endif
      end else begin
         tx_start <= 1'b0;

         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (serve) begin
            owed <= owed - 1'b1;
`ifdef UDP_TX_SEQ_EN
            if (seq_word) begin
               datain  <= seq_num;
               seq_num <= seq_num + 1'b1;
            end else begin
               datain <= mem[rd_ptr];
            end
`else
            datain <= mem[rd_ptr];
`endif
         end else if (data_req) begin
            underrun <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (count >= CW'(THRESH)) begin
                  state    <= START;
                  tx_start <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            START: begin
               owed  <= OW'(WORDS_PER_PKT);
               state <= WAIT_TX;
            end
            WAIT_TX: begin
               if (txen) begin
                  state <= SENDING;
               end
            end
            SENDING: begin
               if (!txen) begin
                  state   <= GAP;
                  gap_cnt <= '0;
               end
            end
            GAP: begin
               if (gap_cnt == GW'(GAP_LAST)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Directed bench for udp_tx_packetizer with WORDS_PER_PKT = 4; covers both UDP_TX_SEQ_EN builds.
module tb_udp_tx_packetizer;

   localparam int unsigned WPP = 4;
`ifdef UDP_TX_SEQ_EN
   localparam int unsigned THRESH = WPP - 1;
   localparam logic [31:0] P3_W0  = 32'h0000_0002;
   localparam logic [31:0] P3_W1  = 32'h0000_0011;
`else
   localparam int unsigned THRESH = WPP;
   localparam logic [31:0] P3_W0  = 32'h0000_0011;
   localparam logic [31:0] P3_W1  = 32'h0000_0012;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        tx_start;
   logic [15:0] tx_data_length;
   logic [15:0] tx_total_length;
   logic        data_req = 1'b0;
   logic [31:0] datain;
   logic        txen = 1'b0;
   logic        busy;
   logic        underrun;

   udp_tx_packetizer #(.WORDS_PER_PKT(WPP), .FIFO_AW(9), .IFG_CYCLES(12)) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .tx_start(tx_start), .tx_data_length(tx_data_length), .tx_total_length(tx_total_length),
      .data_req(data_req), .datain(datain), .txen(txen), .busy(busy), .underrun(underrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] word;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [8];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] w);
      s_valid = 1'b1;
      s_data  = w;
      step();
      s_valid = 1'b0;
   endtask

   task automatic serve(input string nm, input logic [31:0] exp);
      data_req = 1'b1;
      step();
      data_req = 1'b0;
      check(nm, datain, exp);
      step();
   endtask

   task automatic wait_start(input string nm, input int budget);
      int seen = 0;
      for (int i = 0; i < budget; i++) begin
         if (tx_start) begin
            seen = 1;
            break;
         end
         step();
      end
      check(nm, 32'(seen), 32'd1);
   endtask

   task automatic expect_no_start(input string nm, input int cycles);
      int seen = 0;
      for (int i = 0; i < cycles; i++) begin
         if (tx_start) seen = 1;
         step();
      end
      check(nm, 32'(seen), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
`ifdef UDP_TX_SEQ_EN
      tbl[0] = '{32'hA1, 32'h0};
      tbl[1] = '{32'hA2, 32'hA1};
      tbl[2] = '{32'hA3, 32'hA2};
      tbl[3] = '{32'hA4, 32'hA3};
      tbl[4] = '{32'hA5, 32'h1};
      tbl[5] = '{32'hA6, 32'hA4};
      tbl[6] = '{32'h0,  32'hA5};
      tbl[7] = '{32'h0,  32'hA6};
`else
      for (int i = 0; i < 8; i++) tbl[i] = '{32'(i + 1), 32'(i + 1)};
`endif

      do_reset();
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_datain",   datain,        32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      check("rst_s_ready",  32'(s_ready),  32'd1);
      check("data_length",  32'(tx_data_length),  32'd24);
      check("total_length", 32'(tx_total_length), 32'd44);

      // Packet 1: one word short of the threshold must not start a packet.
      for (int i = 0; i < int'(THRESH) - 1; i++) push(tbl[i].word);
      expect_no_start("p1_below_thresh", 20);
      push(tbl[THRESH-1].word);
      wait_start("p1_start", 5);
      txen = 1'b1;
      step();
      check("p1_start_pulse", 32'(tx_start), 32'd0);
      check("p1_busy", 32'(busy), 32'd1);
      for (int j = 0; j < 4; j++) serve($sformatf("p1_word%0d", j), tbl[j].exp);

      // Extra request with nothing owed: datain holds, underrun sticks.
      serve("underrun_hold", tbl[3].exp);
      check("underrun_set", 32'(underrun), 32'd1);

      // Packet 2: below-threshold buffer through the gap, then the last word starts it.
      for (int i = 0; i < int'(THRESH) - 1; i++) push(tbl[THRESH+i].word);
      txen = 1'b0;
      step();
      expect_no_start("p2_below_thresh", 30);
      push(tbl[2*THRESH-1].word);
      wait_start("p2_start", 5);
      txen = 1'b1;
      step();
      for (int j = 0; j < 4; j++) serve($sformatf("p2_word%0d", j), tbl[4+j].exp);
      check("underrun_sticky", 32'(underrun), 32'd1);

      // Inter-frame gap with a full packet already buffered: 12 GAP cycles, one IDLE cycle, then START.
      for (int i = 0; i < 8; i++) push(32'h11 + 32'(i));
      txen = 1'b0;
      step();
      begin
         int first = -1;
         for (int c = 0; c <= 20; c++) begin
            if (tx_start && first < 0) first = c;
            if (first >= 0) break;
            step();
         end
         check("ifg_start_cycle", 32'(first), 32'd13);
      end

      // Packet 3: reset after two words must abandon it and flush the FIFO.
      txen = 1'b1;
      step();
      serve("p3_word0", P3_W0);
      serve("p3_word1", P3_W1);
      rst = 1'b1;
      data_req = 1'b1;
      s_valid = 1'b1;
      s_data = 32'hFFFF_FFFF;
      step();
      rst = 1'b0;
      data_req = 1'b0;
      s_valid = 1'b0;
      txen = 1'b0;
      check("mid_rst_busy",     32'(busy),     32'd0);
      check("mid_rst_tx_start", 32'(tx_start), 32'd0);
      check("mid_rst_datain",   datain,        32'd0);
      check("mid_rst_underrun", 32'(underrun), 32'd0);
      check("mid_rst_s_ready",  32'(s_ready),  32'd1);
      for (int i = 0; i < int'(THRESH) - 1; i++) push(32'h77 + 32'(i));
      expect_no_start("mid_rst_flushed", 30);

      // Fill to depth with no reads; the overflow word must not overwrite slot 0.
      do_reset();
      begin
         int refused = 0;
         for (int i = 0; i < 512; i++) begin
            if (!s_ready) refused++;
            push(32'h100 + 32'(i));
         end
         check("fill_accepted", 32'(refused), 32'd0);
      end
      check("full_s_ready", 32'(s_ready), 32'd0);
      push(32'hDEAD_BEEF);
      check("overflow_s_ready", 32'(s_ready), 32'd0);
`ifdef UDP_TX_SEQ_EN
      serve("full_seq_word", 32'h0);
      check("full_still_full", 32'(s_ready), 32'd0);
`endif
      serve("full_first_word", 32'h100);
      check("full_drained_one", 32'(s_ready), 32'd1);
      check("full_no_underrun", 32'(underrun), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
